nfc_page_programmer: RTL and testbench



---
 rtl/nfc_page_programmer.sv | 163 ++++++++++++++++
 tb/tb_nfc_page_programmer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/nfc_page_programmer.sv
// NAND page programmer for flash B: streams upstream bytes into ascending pages
// using the 80h / 3 address cycles / data / 10h sequence, then waits on ready/busy.
module nfc_page_programmer #(
    parameter int PAGE_BYTES = 512,
    parameter int NUM_PAGES  = 512,
    parameter int BUSY_GUARD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    inout  wire  [7:0] F_IO_B,
    output logic       F_CLE_B,
    output logic       F_ALE_B,
    output logic       F_REN_B,
    output logic       F_WEN_B,
    input  logic       F_RB_B,
    output logic       page_done,
    output logic       done
);

    localparam int CNT_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam int GRD_W = $clog2(BUSY_GUARD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PAGE_BYTES - 1);
    localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'(BUSY_GUARD - 1);
    localparam logic [8:0]       PAGE_LAST  = 9'(NUM_PAGES - 1);

    typedef enum logic [3:0] {
        C80_SET, C80_LAT, A0_SET, A0_LAT, A1_SET, A1_LAT, A2_SET, A2_LAT,
        D_SET, D_LAT, C10_SET, C10_LAT, BUSY_LO, BUSY_HI, DONE
    } state_t;

    state_t           state_r, state_s;
    logic             cle_r, cle_s, ale_r, ale_s, wen_r, wen_s;
    logic [7:0]       io_r, io_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [GRD_W-1:0] guard_r, guard_s;
    logic [8:0]       page_r, page_s;
    logic             page_done_r, page_done_s, done_r, done_s;

    assign F_IO_B    = io_r;
    assign F_CLE_B   = cle_r;
    assign F_ALE_B   = ale_r;
    assign F_WEN_B   = wen_r;
    assign F_REN_B   = 1'b1;
    assign page_done = page_done_r;
    assign done      = done_r;

    // Upstream handshake is open only while waiting for a data byte
    always_comb begin
        s_ready = (state_r == D_SET);
    end

    // State register and registered flash-bus drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= C80_SET;
            cle_r       <= 1'b0;
            ale_r       <= 1'b0;
            wen_r       <= 1'b1;
            io_r        <= 8'h00;
            cnt_r       <= '0;
            guard_r     <= '0;
            page_r      <= 9'd0;
            page_done_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cle_r       <= cle_s;
            ale_r       <= ale_s;
            wen_r       <= wen_s;
            io_r        <= io_s;
            cnt_r       <= cnt_s;
            guard_r     <= guard_s;
            page_r      <= page_s;
            page_done_r <= page_done_s;
            done_r      <= done_s;
        end
    end

    // Next-state and next-output logic; each SET drops WEN, each LAT raises it
    always_comb begin
        state_s     = state_r;
        cle_s       = cle_r;
        ale_s       = ale_r;
        wen_s       = wen_r;
        io_s        = io_r;
        cnt_s       = cnt_r;
        guard_s     = guard_r;
        page_s      = page_r;
        page_done_s = 1'b0;
        done_s      = done_r;
        case (state_r)
            C80_SET: begin cle_s = 1'b1; ale_s = 1'b0; io_s = 8'h80; wen_s = 1'b0; state_s = C80_LAT; end
            C80_LAT: begin wen_s = 1'b1; state_s = A0_SET; end
            A0_SET:  begin cle_s = 1'b0; ale_s = 1'b1; io_s = 8'h00; wen_s = 1'b0; state_s = A0_LAT; end
            A0_LAT:  begin wen_s = 1'b1; state_s = A1_SET; end
            A1_SET:  begin io_s = page_r[7:0]; wen_s = 1'b0; state_s = A1_LAT; end
            A1_LAT:  begin wen_s = 1'b1; state_s = A2_SET; end
            A2_SET:  begin io_s = {7'b0000000, page_r[8]}; wen_s = 1'b0; state_s = A2_LAT; end
            A2_LAT:  begin wen_s = 1'b1; ale_s = 1'b0; state_s = D_SET; end
            D_SET: begin
                // A stalled upstream leaves WEN high and the bus untouched
                if (s_valid && s_ready) begin
                    io_s    = s_data;
                    wen_s   = 1'b0;
                    state_s = D_LAT;
                end else begin
                    wen_s   = 1'b1;
                    state_s = D_SET;
                end
            end
            D_LAT: begin
                wen_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    state_s = C10_SET;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                    state_s = D_SET;
                end
            end
            C10_SET: begin cle_s = 1'b1; io_s = 8'h10; wen_s = 1'b0; state_s = C10_LAT; end
            C10_LAT: begin wen_s = 1'b1; cle_s = 1'b0; guard_s = '0; state_s = BUSY_LO; end
            BUSY_LO: begin
                // A flash that never signals busy must not stall the sequence
                if (!F_RB_B || (guard_r == GUARD_LAST)) begin
                    state_s = BUSY_HI;
                end else begin
                    guard_s = guard_r + GRD_W'(1);
                end
            end
            BUSY_HI: begin
                if (F_RB_B) begin
                    page_done_s = 1'b1;
                    if (page_r == PAGE_LAST) begin
                        state_s = DONE;
                    end else begin
                        page_s  = page_r + 9'd1;
                        state_s = C80_SET;
                    end
                end else begin
                    state_s = BUSY_HI;
                end
            end
            DONE: begin
                cle_s   = 1'b0;
                ale_s   = 1'b0;
                wen_s   = 1'b1;
                done_s  = 1'b1;
                state_s = DONE;
            end
            default: begin
                cle_s   = 1'b0;
                ale_s   = 1'b0;
                wen_s   = 1'b1;
                state_s = C80_SET;
            end
        endcase
    end

endmodule

// File: tb/tb_nfc_page_programmer.sv
// Randomized scoreboard bench for nfc_page_programmer with a flash-B ready/busy model.
`timescale 1ns/1ps
module tb_nfc_page_programmer;

    localparam int PB       = 32;
    localparam int NP       = 260;
    localparam int BG       = 4;
    localparam int BUSY_LEN = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    wire  [7:0] f_io;
    logic       f_cle, f_ale, f_ren, f_wen;
    logic       f_rb = 1'b1;
    logic       page_done, done;

    always #5 clk = ~clk;

    nfc_page_programmer #(.PAGE_BYTES(PB), .NUM_PAGES(NP), .BUSY_GUARD(BG)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .F_IO_B(f_io), .F_CLE_B(f_cle), .F_ALE_B(f_ale), .F_REN_B(f_ren),
        .F_WEN_B(f_wen), .F_RB_B(f_rb), .page_done(page_done), .done(done)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [9:0] exp_q[$];
    logic [7:0] src [0:NP*PB];
    int         idx, gap, max_gap;

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: every page is 80h, column 00h, page low/high bytes, data, 10h
    task automatic push_all();
        exp_q.delete();
        for (int p = 0; p < NP; p++) begin
            exp_q.push_back({2'b10, 8'h80});
            exp_q.push_back({2'b01, 8'h00});
            exp_q.push_back({2'b01, 8'(p % 256)});
            exp_q.push_back({2'b01, 8'(p / 256)});
            for (int i = 0; i < PB; i++) exp_q.push_back({2'b00, src[p*PB + i]});
            exp_q.push_back({2'b10, 8'h10});
        end
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_cle"}, int'(f_cle), 0);
        chk({tag, "_ale"}, int'(f_ale), 0);
        chk({tag, "_wen"}, int'(f_wen), 1);
        chk({tag, "_ren"}, int'(f_ren), 1);
        chk({tag, "_io"}, int'(f_io), 0);
        chk({tag, "_s_ready"}, int'(s_ready), 0);
        chk({tag, "_page_done"}, int'(page_done), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Source driver: holds each byte until accepted, random gaps between bytes
    task automatic cycle_step();
        logic hs;
        int   pg;
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        pg      = idx / PB;
        max_gap = (pg < 2) ? 0 : ((pg < 10) ? 7 : 1);
        if (hs) begin
            idx++;
            gap = $urandom_range(0, max_gap);
        end else if (gap > 0) begin
            gap--;
        end
        s_valid = (gap == 0);
        s_data  = (idx < NP*PB) ? src[idx] : 8'hA5;
    endtask

    // Monitor plus flash-B model: latch on WEN rising edge, pop and compare
    int         pos, pages, cyc, t10, low_run, busy_cnt, dt;
    logic       wen_prev, stuck, done_exp;
    logic [9:0] held;

    always @(negedge clk) begin
        if (rst) begin
            pos = 0; pages = 0; low_run = 0; busy_cnt = 0; t10 = 0;
            wen_prev = 1'b1; stuck = 1'b0; done_exp = 1'b0; f_rb = 1'b1;
        end else begin
            cyc++;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) f_rb = 1'b1;
            end
            if (!f_wen) begin
                low_run++;
                held = {f_cle, f_ale, f_io};
            end else if (!wen_prev) begin
                chk("wen_low_cycles", low_run, 1);
                chk("io_hold_after_wen", int'(f_io), int'(held[7:0]));
                if (exp_q.size() == 0) chk("extra_bus_cycle", int'(held), -1);
                else chk("bus_cycle", int'(held), int'(exp_q.pop_front()));
                low_run = 0;
                pos++;
                if (pos == PB + 5) begin
                    t10   = cyc;
                    stuck = (pages == 5 || pages == 6);
                    if (!stuck) begin
                        f_rb     = 1'b0;
                        busy_cnt = BUSY_LEN;
                    end
                end
            end
            if (s_ready) chk("s_ready_legal", int'(pos >= 4 && pos < 4 + PB && f_wen && !done), 1);
            if (page_done) begin
                dt = cyc - t10;
                chk("page_done_pos", pos, PB + 5);
                chk("page_done_rb", int'(f_rb), 1);
                if (stuck) chk("guard_latency", int'(dt >= BG && dt <= BG + 2), 1);
                else chk("page_done_after_busy", int'(dt > BUSY_LEN), 1);
                pos = 0;
                pages++;
            end else if (pos == PB + 5 && cyc - t10 > 40) begin
                chk("page_done_timeout", cyc - t10, 40);
                t10 = cyc;
            end
            if (done != done_exp || done_exp) chk("done", int'(done), int'(done_exp));
            if (page_done && pages == NP) done_exp = 1'b1;
            wen_prev = f_wen;
        end
    end

    initial begin
        int n;
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
        idx = 0; gap = 0; max_gap = 0; cyc = 0;
        foreach (src[i]) src[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("init");
        push_all();
        @(posedge clk);
        #1 rst = 1'b0;

        n = 0;
        while (idx < 3*PB + 10 && n < 20000) begin cycle_step(); n++; end
        if (idx < 3*PB + 10) chk("abort_point_reached", idx, 3*PB + 10);
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("abort");
        idx = 0; gap = 0;
        push_all();
        @(posedge clk);
        #1 rst = 1'b0;

        n = 0;
        while (!done && n < 60000) begin cycle_step(); n++; end
        chk("done_reached", int'(done), 1);
        repeat (20) cycle_step();
        @(negedge clk);
        chk("pages_programmed", pages, NP);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_sticky", int'(done), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
